// File: rtl/afe_seq_ctrl.sv
// rtl/afe_seq_ctrl.sv - AFE4490 SPI transaction sequencer: ADC_RDY result bursts plus host register access
module afe_seq_ctrl #(
  parameter logic [7:0] RD_BASE     = 8'h2A,
  parameter int         NUM_RD      = 6,
  parameter int         TIMEOUT_CYC = 1024,
  parameter int         GAP_CYC     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_adc_rdy,
  output logic [7:0]  o_spi_addr,
  output logic [23:0] o_spi_wr_data,
  output logic        o_spi_rd_wr,
  output logic        o_spi_dv,
  input  logic        i_spi_done,
  input  logic [23:0] i_spi_rd_data,
  input  logic        i_host_req,
  input  logic        i_host_rd,
  input  logic [7:0]  i_host_addr,
  input  logic [23:0] i_host_wdata,
  output logic        o_host_ack,
  output logic [23:0] o_host_rdata,
  output logic [23:0] o_sample,
  output logic [2:0]  o_sample_idx,
  output logic        o_sample_valid,
  output logic        o_overrun,
  output logic        o_err,
  input  logic        i_err_clr
);

  localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]     GAP_LAST = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, FINISH} state_t;
  state_t state, state_nxt;

  logic          sync1, sync2, sync3, rdy_edge;
  logic          burst_pend;
  logic          cur_burst, cur_seq;
  logic [7:0]    cur_addr;
  logic [23:0]   cur_wdata;
  logic [3:0]    cur_nrd;
  logic [3:0]    step;
  logic [3:0]    gap_cnt;
  logic [TW-1:0] to_cnt;
  logic [23:0]   rd_buf;

  logic busy_burst, sel_burst, sel_host, last_step, rd_step, timeout, done_w;

  always_comb begin
    busy_burst = (state != IDLE) && cur_burst;
    sel_burst  = burst_pend;
    // A host request arriving with a fresh edge waits one cycle so the burst keeps priority
    sel_host   = !burst_pend && !(rdy_edge && i_en) && i_host_req && !o_host_ack;
    last_step  = cur_seq ? (step == cur_nrd + 4'd1) : 1'b1;
    rd_step    = cur_seq && (step != 4'd0) && (step <= cur_nrd);
    done_w     = (state == WAIT) && i_spi_done;
    timeout    = (state == WAIT) && !i_spi_done && (to_cnt == TO_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (sel_burst || sel_host) state_nxt = ISSUE;
      ISSUE:  state_nxt = WAIT;
      WAIT: begin
        if (i_spi_done) begin
          if (last_step)         state_nxt = FINISH;
          else if (GAP_CYC == 0) state_nxt = ISSUE;
          else                   state_nxt = GAP;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      GAP:    if (gap_cnt == GAP_LAST) state_nxt = ISSUE;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_spi_dv      = (state == ISSUE);
    o_spi_addr    = 8'h00;
    o_spi_wr_data = 24'h000000;
    o_spi_rd_wr   = 1'b0;
    if (state == ISSUE || state == WAIT || state == GAP) begin
      if (!cur_seq) begin
        o_spi_addr    = cur_addr;
        o_spi_wr_data = cur_wdata;
      end else if (step == 4'd0) begin
        o_spi_wr_data = 24'h000001;
      end else if (rd_step) begin
        o_spi_addr  = cur_addr + 8'(step) - 8'd1;
        o_spi_rd_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1          <= 1'b0;
      sync2          <= 1'b0;
      sync3          <= 1'b0;
      rdy_edge       <= 1'b0;
      burst_pend     <= 1'b0;
      cur_burst      <= 1'b0;
      cur_seq        <= 1'b0;
      cur_addr       <= 8'h00;
      cur_wdata      <= 24'h000000;
      cur_nrd        <= 4'd0;
      step           <= 4'd0;
      gap_cnt        <= 4'd0;
      to_cnt         <= '0;
      rd_buf         <= 24'h000000;
      o_host_ack     <= 1'b0;
      o_host_rdata   <= 24'h000000;
      o_sample       <= 24'h000000;
      o_sample_idx   <= 3'd0;
      o_sample_valid <= 1'b0;
      o_overrun      <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      sync1    <= i_adc_rdy;
      sync2    <= sync1;
      sync3    <= sync2;
      rdy_edge <= sync2 && !sync3;

      o_overrun <= rdy_edge && (burst_pend || busy_burst);
      if (rdy_edge && i_en && !burst_pend && !busy_burst)
        burst_pend <= 1'b1;
      else if (timeout || (state == FINISH && cur_burst))
        burst_pend <= 1'b0;

      if (timeout)        o_err <= 1'b1;
      else if (i_err_clr) o_err <= 1'b0;

      o_host_ack     <= (state == FINISH) && !cur_burst;
      if (state == FINISH && !cur_burst && cur_seq)
        o_host_rdata <= rd_buf;

      o_sample_valid <= done_w && cur_burst && rd_step;
      if (done_w && cur_burst && rd_step) begin
        o_sample     <= i_spi_rd_data;
        o_sample_idx <= 3'(step - 4'd1);
      end

      case (state)
        IDLE: begin
          step <= 4'd0;
          if (sel_burst) begin
            cur_burst <= 1'b1;
            cur_seq   <= 1'b1;
            cur_addr  <= RD_BASE;
            cur_wdata <= 24'h000000;
            cur_nrd   <= 4'(NUM_RD);
          end else if (sel_host) begin
            // A host read reuses the burst framing with a single read step
            cur_burst <= 1'b0;
            cur_seq   <= i_host_rd;
            cur_addr  <= i_host_addr;
            cur_wdata <= i_host_wdata;
            cur_nrd   <= 4'd1;
          end
        end
        ISSUE: to_cnt <= TW'(1);
        WAIT: begin
          to_cnt  <= to_cnt + TW'(1);
          gap_cnt <= 4'd0;
          if (i_spi_done) begin
            if (rd_step) rd_buf <= i_spi_rd_data;
            if (!last_step && GAP_CYC == 0) step <= step + 4'd1;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 4'd1;
          if (gap_cnt == GAP_LAST) step <= step + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
